// File: rtl/ram_nxw_2r1w.sv
// 2-read/1-write register-file RAM with write/sweep forwarding and a one-word-per-cycle clear sequencer.
// Optional per-word even parity with error injection when PARITY_EN is defined.
module ram_nxw_2r1w #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] Write_Address,
  input  logic              Write_Enable,
  input  logic [ADDR_W-1:0] Read_Address_1,
  input  logic              Read_Enable_1,
  input  logic [ADDR_W-1:0] Read_Address_2,
  input  logic              Read_Enable_2,
  input  logic              Clear_Start,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  output logic              Busy,
  output logic              Clear_Done,
  output logic              Write_Drop,
  input  logic              Parity_Flip,
  output logic              Parity_Error_1,
  output logic              Parity_Error_2
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept;
  logic              sweeping;
  logic [DATA_W-1:0] rd_word_1, rd_word_2;

  assign sweeping   = (state == CLEAR);
  assign wr_accept  = Write_Enable && !sweeping;
  assign Busy       = sweeping;
  assign Clear_Done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Clear_Start) next_state = CLEAR;
      CLEAR:   if (ptr == LAST_ADDR) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pointer parks at 0 outside the sweep so each sweep starts from word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ptr <= '0;
    else if (sweeping) ptr <= ptr + 1'b1;
    else               ptr <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweeping) begin
      mem[ptr] <= '0;
    end else if (wr_accept) begin
      mem[Write_Address] <= Write_Data;
    end
  end

  // Same-cycle write or sweep to the read address wins over the stored word.
  always_comb begin
    rd_word_1 = mem[Read_Address_1];
    rd_word_2 = mem[Read_Address_2];
    if (wr_accept && Write_Address == Read_Address_1) rd_word_1 = Write_Data;
    else if (sweeping && ptr == Read_Address_1)       rd_word_1 = '0;
    if (wr_accept && Write_Address == Read_Address_2) rd_word_2 = Write_Data;
    else if (sweeping && ptr == Read_Address_2)       rd_word_2 = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Read_Data_1 <= '0;
      Read_Data_2 <= '0;
      Write_Drop  <= 1'b0;
    end else begin
      if (Read_Enable_1) Read_Data_1 <= rd_word_1;
      if (Read_Enable_2) Read_Data_2 <= rd_word_2;
      Write_Drop <= Write_Enable && sweeping;
    end
  end

`ifdef PARITY_EN
  logic par [DEPTH];
  logic rd_par_1, rd_par_2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) par[i] <= 1'b0;
    end else if (sweeping) begin
      par[ptr] <= 1'b0;
    end else if (wr_accept) begin
      par[Write_Address] <= (^Write_Data) ^ Parity_Flip;
    end
  end

  // Parity bit follows the same forwarding priority as the data word.
  always_comb begin
    rd_par_1 = par[Read_Address_1];
    rd_par_2 = par[Read_Address_2];
    if (wr_accept && Write_Address == Read_Address_1) rd_par_1 = (^Write_Data) ^ Parity_Flip;
    else if (sweeping && ptr == Read_Address_1)       rd_par_1 = 1'b0;
    if (wr_accept && Write_Address == Read_Address_2) rd_par_2 = (^Write_Data) ^ Parity_Flip;
    else if (sweeping && ptr == Read_Address_2)       rd_par_2 = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Parity_Error_1 <= 1'b0;
      Parity_Error_2 <= 1'b0;
    end else begin
      if (Read_Enable_1) Parity_Error_1 <= rd_par_1 ^ (^rd_word_1);
      if (Read_Enable_2) Parity_Error_2 <= rd_par_2 ^ (^rd_word_2);
    end
  end
`else
  logic unused_parity_flip;
  assign unused_parity_flip = Parity_Flip;
  assign Parity_Error_1     = 1'b0;
  assign Parity_Error_2     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_nxw_2r1w.sv
// Directed self-checking bench for ram_nxw_2r1w (DATA_W=8, ADDR_W=3); parity expectations follow PARITY_EN.
module tb_ram_nxw_2r1w;

  logic       clk;
  logic       reset;
  logic [7:0] Write_Data;
  logic [2:0] Write_Address;
  logic       Write_Enable;
  logic [2:0] Read_Address_1;
  logic       Read_Enable_1;
  logic [2:0] Read_Address_2;
  logic       Read_Enable_2;
  logic       Clear_Start;
  logic [7:0] Read_Data_1;
  logic [7:0] Read_Data_2;
  logic       Busy;
  logic       Clear_Done;
  logic       Write_Drop;
  logic       Parity_Flip;
  logic       Parity_Error_1;
  logic       Parity_Error_2;

  int tests_run;
  int fail_count;

`ifdef PARITY_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  ram_nxw_2r1w #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .Write_Data     (Write_Data),
    .Write_Address  (Write_Address),
    .Write_Enable   (Write_Enable),
    .Read_Address_1 (Read_Address_1),
    .Read_Enable_1  (Read_Enable_1),
    .Read_Address_2 (Read_Address_2),
    .Read_Enable_2  (Read_Enable_2),
    .Clear_Start    (Clear_Start),
    .Read_Data_1    (Read_Data_1),
    .Read_Data_2    (Read_Data_2),
    .Busy           (Busy),
    .Clear_Done     (Clear_Done),
    .Write_Drop     (Write_Drop),
    .Parity_Flip    (Parity_Flip),
    .Parity_Error_1 (Parity_Error_1),
    .Parity_Error_2 (Parity_Error_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and advances past the next rising edge.
  task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                               input logic re1, input logic [2:0] ra1,
                               input logic re2, input logic [2:0] ra2,
                               input logic cs, input logic flip);
    Write_Enable   = we;
    Write_Address  = wa;
    Write_Data     = wd;
    Read_Enable_1  = re1;
    Read_Address_1 = ra1;
    Read_Enable_2  = re2;
    Read_Address_2 = ra2;
    Clear_Start    = cs;
    Parity_Flip    = flip;
    tick();
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    reset = 1'b0;
    Write_Enable = 1'b0; Write_Address = '0; Write_Data = '0;
    Read_Enable_1 = 1'b0; Read_Address_1 = '0;
    Read_Enable_2 = 1'b0; Read_Address_2 = '0;
    Clear_Start = 1'b0; Parity_Flip = 1'b0;
    tick();
    tick();
    checkOutput("rst_rd1", Read_Data_1, 0);
    checkOutput("rst_rd2", Read_Data_2, 0);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Clear_Done, 0);
    checkOutput("rst_drop", Write_Drop, 0);
    checkOutput("rst_pe1", Parity_Error_1, 0);
    checkOutput("rst_pe2", Parity_Error_2, 0);
    reset = 1'b1;
    tick();

    // Every word reads zero after reset.
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 8'h00, 1, 3'(a), 1, 3'(7 - a), 0, 0);
      checkOutput("init_rd1", Read_Data_1, 0);
      checkOutput("init_rd2", Read_Data_2, 0);
    end
    checkOutput("init_pe1", Parity_Error_1, 0);

    // Basic write then dual read, then hold with enables low.
    applyStimulus(1, 3, 8'hA5, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 6, 8'h5A, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 3, 1, 6, 0, 0);
    checkOutput("wr_rd1", Read_Data_1, 8'hA5);
    checkOutput("wr_rd2", Read_Data_2, 8'h5A);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_rd1", Read_Data_1, 8'hA5);
    checkOutput("hold_rd2", Read_Data_2, 8'h5A);
    applyStimulus(0, 0, 8'h00, 1, 3, 1, 3, 0, 0);
    checkOutput("same_rd1", Read_Data_1, 8'hA5);
    checkOutput("same_rd2", Read_Data_2, 8'hA5);

    // Write forwarding to port 1 while port 2 sees an untouched word.
    applyStimulus(1, 1, 8'h22, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 8'h11, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 8'h77, 1, 2, 1, 1, 0, 0);
    checkOutput("fwd_rd1", Read_Data_1, 8'h77);
    checkOutput("fwd_rd2", Read_Data_2, 8'h22);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 2, 0, 0);
    checkOutput("fwd_stored", Read_Data_2, 8'h77);

    // Fill with 0xFF then sweep; drops, ignored restart and sweep forwarding.
    for (int a = 0; a < 8; a++) applyStimulus(1, 3'(a), 8'hFF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("sweep_busy", Busy, 1);
      checkOutput("sweep_done_low", Clear_Done, 0);
      applyStimulus((i == 3 || i == 5), (i == 3) ? 3'd4 : 3'd1, 8'h33,
                    1, 3'(i), 1, 7, (i == 5), 0);
      checkOutput("sweep_fwd_rd1", Read_Data_1, 0);
      checkOutput("sweep_rd2", Read_Data_2, (i == 7) ? 32'h0 : 32'hFF);
      checkOutput("sweep_drop", Write_Drop, (i == 3 || i == 5) ? 1 : 0);
    end
    checkOutput("done_busy", Busy, 0);
    checkOutput("done_pulse", Clear_Done, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_done", Clear_Done, 0);
    checkOutput("idle_busy", Busy, 0);
    checkOutput("idle_drop", Write_Drop, 0);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 8'h00, 1, 3'(a), 1, 3'(7 - a), 0, 0);
      checkOutput("cleared_rd1", Read_Data_1, 0);
      checkOutput("cleared_rd2", Read_Data_2, 0);
    end

    // Write accepted alongside Clear_Start, then reset on the 3rd Busy cycle.
    applyStimulus(1, 5, 8'h44, 0, 0, 0, 0, 1, 0);
    checkOutput("mid_busy1", Busy, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 1, 5, 0, 0);
    checkOutput("start_wr_kept", Read_Data_2, 8'h44);
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_busy3", Busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", Busy, 0);
    checkOutput("mid_rst_done", Clear_Done, 0);
    checkOutput("mid_rst_rd2", Read_Data_2, 0);
    tick();
    tick();
    checkOutput("mid_rst_done2", Clear_Done, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("post_rst_done", Clear_Done, 0);
      checkOutput("post_rst_busy", Busy, 0);
    end
    applyStimulus(0, 0, 8'h00, 1, 5, 1, 7, 0, 0);
    checkOutput("post_rst_rd1", Read_Data_1, 0);
    checkOutput("post_rst_rd2", Read_Data_2, 0);

    // Parity injection on stored and forwarded data.
    applyStimulus(1, 5, 8'h0F, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 1, 5, 0, 0, 0, 0);
    checkOutput("par_rd1", Read_Data_1, 8'h0F);
    checkOutput("par_err1", Parity_Error_1, PAR_ON);
    applyStimulus(1, 5, 8'h0F, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 5, 0, 0, 0, 0);
    checkOutput("par_clean1", Parity_Error_1, 0);
    applyStimulus(1, 6, 8'h03, 0, 0, 1, 6, 0, 1);
    checkOutput("par_fwd_rd2", Read_Data_2, 8'h03);
    checkOutput("par_fwd_err2", Parity_Error_2, PAR_ON);
    checkOutput("par_hold1", Parity_Error_1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/ram_nxw_2r1w.md
Name: ram_nxw_2r1w

Overview:
Parametrised 2-read/1-write register-file RAM: DEPTH = 2**ADDR_W words of DATA_W bits, one write port and two independent registered read ports.
Same-cycle write-to-read forwarding keeps the read ports coherent with writes.
A built-in clear sequencer zeroes the array one word per cycle on command.
Generalises the 2x2-bit, two-read-port row RAM to arbitrary width and depth, and serves as the datapath register file and scratch store.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
Write_Data  input  DATA_W  write word
Write_Address  input  ADDR_W  write address
Write_Enable  input  1  write request
Read_Address_1  input  ADDR_W  read port 1 address
Read_Enable_1  input  1  read port 1 capture enable
Read_Address_2  input  ADDR_W  read port 2 address
Read_Enable_2  input  1  read port 2 capture enable
Clear_Start  input  1  start array clear sweep
Read_Data_1  output  DATA_W  registered read data, port 1
Read_Data_2  output  DATA_W  registered read data, port 2
Busy  output  1  clear sweep in progress
Clear_Done  output  1  one-cycle pulse when the sweep completes
Write_Drop  output  1  one-cycle pulse: previous-cycle write was rejected
Parity_Flip  input  1  parity error injection (used only with PARITY_EN)
Parity_Error_1  output  1  parity error flag, port 1 (0 without PARITY_EN)
Parity_Error_2  output  1  parity error flag, port 2 (0 without PARITY_EN)

Behaviour:
- Reset (reset low, asynchronous):
  - All memory words = 0.
  - Read_Data_1/2 = 0, Busy = 0, Clear_Done = 0, Write_Drop = 0, Parity_Error_1/2 = 0.
  - FSM = IDLE, sweep pointer = 0.
- Write: accepted at the rising edge when Write_Enable=1 and FSM != CLEAR. mem[Write_Address] <= Write_Data.
- Write rejected in CLEAR: memory unchanged; Write_Drop = 1 for the next cycle only.
- Read latency is 1 cycle. At the edge, if Read_Enable_k=1, Read_Data_k <= the word at Read_Address_k. If Read_Enable_k=0, Read_Data_k holds its value.
- Forwarding: if an accepted write targets Read_Address_k in the same cycle, Read_Data_k captures Write_Data (new data).
- Sweep forwarding: if the sweep clears Read_Address_k in the same cycle, Read_Data_k captures 0.
- Both ports may read the same address; both get identical data.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when Clear_Start=1; pointer <= 0.
  - CLEAR: each cycle mem[pointer] <= 0, then pointer++. When pointer == DEPTH-1, that word is cleared and the FSM goes to DONE.
  - DONE: Clear_Done = 1 for this one cycle, then -> IDLE.
  - Busy = 1 exactly while in CLEAR, i.e. DEPTH cycles starting the cycle after Clear_Start is sampled.
- Clear_Start in CLEAR or DONE is ignored (no restart, no queueing).
- Clear_Start together with Write_Enable in IDLE: the write is accepted that cycle; its word is zeroed later by the sweep.
- Reset mid-sweep: immediate return to IDLE with the full reset state above. No Clear_Done pulse.
- Pointer width is ADDR_W. No wrap beyond DEPTH-1 is possible, because the FSM leaves CLEAR at the last word.
- Reads are allowed during CLEAR and return current contents (subject to sweep forwarding).

Optional Feature:
Macro PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from Write_Data on every accepted write.
  - If Parity_Flip=1 during an accepted write, the stored parity bit is inverted (error injection).
  - The sweep and reset store parity 0 with data 0.
  - When Read_Data_k is captured, Parity_Error_k <= (stored parity != recomputed parity of captured data). Forwarded data never flags an error unless Parity_Flip=1 on that write.
  - When Read_Enable_k=0, Parity_Error_k holds with Read_Data_k.
- Not defined: no parity storage; Parity_Flip is ignored; Parity_Error_1/2 are tied to 0.

Test Plan:
- Reset then read all: deassert reset, read addresses 0..7 on both ports -> Read_Data_1/2 = 0x00 one cycle after each enable; all flags 0.
- Write/read: write 0xA5 @3 and 0x5A @6, then read port1 @3 and port2 @6 in the same cycle -> next cycle Read_Data_1=0xA5, Read_Data_2=0x5A; with both enables low the next cycle, outputs hold.
- Forwarding: preload 0x11 @2, then write 0x77 @2 while port1 reads @2 and port2 reads @1 -> Read_Data_1=0x77 next cycle, port2 shows the old @1 value.
- Clear sweep: fill all words with 0xFF, pulse Clear_Start -> Busy high for exactly 8 cycles, Clear_Done one cycle after; a write of 0x33 @4 mid-sweep gives Write_Drop=1 next cycle; reads afterwards return 0x00 everywhere.
- Reset mid-sweep: assert reset on the 3rd Busy cycle -> Busy, Clear_Done and outputs go 0 immediately; Clear_Done never pulses; memory reads 0.
- PARITY_EN: write 0x0F @5 with Parity_Flip=1, read @5 -> Parity_Error_1=1; rewrite with Parity_Flip=0 -> 0; without the macro, Parity_Error_1/2 stay 0.
